// File: rtl/mult_disp_pkg.sv
// Shared types and seven-segment constants for the multiplier digit scroller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mult_disp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIG2 = 3'd1,
        DIG1 = 3'd2,
        DIG0 = 3'd3,
        GAP  = 3'd4
    } disp_state_t;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to seven-segment pattern decoder.
// Latency: purely combinational.
// Backpressure: none.
module hex7seg
    import mult_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the sixteen hex glyphs
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mult_digit_scroller.sv
// Scrolls a 12-bit product over one seven-segment digit: hi, mid, lo nibble, blank, repeat.
// Latency: first digit shows the cycle after the accepting edge.
// Backpressure: prod_ready only in IDLE and GAP; upstream holds prod_valid/prod otherwise.
module mult_digit_scroller
    import mult_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prod_valid,
    input  logic [11:0] prod,
    output logic        prod_ready,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        busy
);

    localparam int            CW       = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    disp_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [11:0]   hold, hold_nxt;
    logic          xfer;
    logic          last;
    logic [3:0]    nib;
    logic [6:0]    hex_seg;

    // State, phase counter and held product; reset drops everything back to an idle dash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hold  <= hold_nxt;
        end
    end

    // Next-state: phases advance on counter expiry; an accepted product overrides expiry
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CW'(1);
        hold_nxt   = hold;
        prod_ready = (state == IDLE) || (state == GAP);
        xfer       = prod_valid && prod_ready;
        last       = (cnt == CNT_LAST);

        case (state)
            IDLE: cnt_nxt = '0;
            DIG2: if (last) begin state_nxt = DIG1; cnt_nxt = '0; end
            DIG1: if (last) begin state_nxt = DIG0; cnt_nxt = '0; end
            DIG0: if (last) begin state_nxt = GAP;  cnt_nxt = '0; end
            GAP:  if (last) begin state_nxt = DIG2; cnt_nxt = '0; end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (xfer) begin
            hold_nxt  = prod;
            state_nxt = DIG2;
            cnt_nxt   = '0;
        end
    end

    // Pick the nibble for the current digit phase
    always_comb begin
        nib = hold[3:0];
        case (state)
            DIG2:    nib = hold[11:8];
            DIG1:    nib = hold[7:4];
            default: nib = hold[3:0];
        endcase
    end

    hex7seg u_hex7seg (
        .hex (nib),
        .seg (hex_seg)
    );

    // Output mux: digits decode, GAP blanks, IDLE shows a dash
    always_comb begin
        segments = SEG_DASH;
        case (state)
            DIG2, DIG1, DIG0: segments = hex_seg;
            GAP:              segments = SEG_BLANK;
            default:          segments = SEG_DASH;
        endcase
        dp   = (state == DIG0);
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_mult_digit_scroller.sv
// Directed bench for mult_digit_scroller with HOLD_CYCLES=4.
// Latency: checks one-cycle transfer-to-display.
// Backpressure: exercises ignored prod_valid while busy.
module tb_mult_digit_scroller;

    localparam int HC = 4;

    logic        clk;
    logic        rst;
    logic        prod_valid;
    logic [11:0] prod;
    logic        prod_ready;
    logic [6:0]  segments;
    logic        dp;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic        v;
        logic [11:0] p;
        logic [6:0]  seg;
        logic        d;
        logic        b;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] enc [16];

    mult_digit_scroller #(.HOLD_CYCLES(HC)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .segments   (segments),
        .dp         (dp),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_n(input int n, input logic r, input logic v, input logic [11:0] p,
                         input logic [6:0] s, input logic d, input logic b, input logic rd);
        for (int k = 0; k < n; k++) begin
            vec_t t;
            t.r = r; t.v = v; t.p = p; t.seg = s; t.d = d; t.b = b; t.rdy = rd;
            vecs.push_back(t);
        end
    endtask

    task automatic chk(input string name, input logic [6:0] s, input logic d,
                       input logic b, input logic rd);
        checks++;
        if (segments !== s) begin
            failures++;
            $display("FAIL %s segments got=%h want=%h", name, segments, s);
        end
        checks++;
        if (dp !== d) begin
            failures++;
            $display("FAIL %s dp got=%b want=%b", name, dp, d);
        end
        checks++;
        if (busy !== b) begin
            failures++;
            $display("FAIL %s busy got=%b want=%b", name, busy, b);
        end
        checks++;
        if (prod_ready !== rd) begin
            failures++;
            $display("FAIL %s prod_ready got=%b want=%b", name, prod_ready, rd);
        end
    endtask

    // Hold prod_valid until the DUT is ready, then let the accepting edge pass
    task automatic transfer(input logic [11:0] p, input string name);
        int budget;
        budget = 40;
        @(negedge clk);
        prod_valid = 1'b1;
        prod       = p;
        #1;
        while (!prod_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (!prod_ready) begin
            checks++;
            failures++;
            $display("FAIL %s ready_timeout got=0 want=1", name);
        end
        @(negedge clk);
        prod_valid = 1'b0;
        #1;
    endtask

    initial begin
        enc = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        // Each vector: inputs held across one clock; outputs checked before that edge
        add_n(1, 1, 0, 12'h000, 7'h40, 0, 0, 1);   // in reset
        add_n(3, 0, 0, 12'h000, 7'h40, 0, 0, 1);   // idle
        add_n(1, 0, 1, 12'hA3F, 7'h40, 0, 0, 1);   // transfer edge
        add_n(4, 0, 0, 12'h000, 7'h77, 0, 1, 0);   // DIG2 'A'
        add_n(1, 0, 0, 12'h000, 7'h4F, 0, 1, 0);   // DIG1 '3'
        add_n(3, 0, 1, 12'h123, 7'h4F, 0, 1, 0);   // ignored valid
        add_n(4, 0, 0, 12'h000, 7'h71, 1, 1, 0);   // DIG0 'F'
        add_n(4, 0, 0, 12'h000, 7'h00, 0, 1, 1);   // GAP
        add_n(4, 0, 0, 12'h000, 7'h77, 0, 1, 0);   // repeat
        add_n(4, 0, 0, 12'h000, 7'h4F, 0, 1, 0);
        add_n(4, 0, 0, 12'h000, 7'h71, 1, 1, 0);
        add_n(3, 0, 0, 12'h000, 7'h00, 0, 1, 1);
        add_n(1, 0, 1, 12'h888, 7'h00, 0, 1, 1);   // transfer on last GAP cycle
        add_n(8, 0, 0, 12'h000, 7'h7F, 0, 1, 0);   // DIG2, DIG1 of 888
        add_n(4, 0, 0, 12'h000, 7'h7F, 1, 1, 0);   // DIG0
        add_n(4, 0, 0, 12'h000, 7'h00, 0, 1, 1);   // GAP
        add_n(1, 0, 0, 12'h000, 7'h7F, 0, 1, 0);   // 888 repeats, never A3F

        rst        = 1'b1;
        prod_valid = 1'b0;
        prod       = '0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst        = vecs[i].r;
            prod_valid = vecs[i].v;
            prod       = vecs[i].p;
            #1;
            chk($sformatf("vec%0d", i), vecs[i].seg, vecs[i].d, vecs[i].b, vecs[i].rdy);
        end

        // Reset in the middle of DIG0 of 0x0F0
        transfer(12'h0F0, "rst_seq");
        chk("rst_dig2", 7'h3F, 0, 1, 0);
        repeat (HC) @(negedge clk);
        #1;
        chk("rst_dig1", 7'h71, 0, 1, 0);
        repeat (HC + 1) @(negedge clk);
        #1;
        chk("rst_dig0", 7'h3F, 1, 1, 0);
        rst = 1'b1;
        #1;
        chk("rst_async", 7'h40, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3 * HC + 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d", k), 7'h40, 0, 0, 1);
        end

        // Every nibble value in every digit position
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  h, m, l;
            h = 4'(i);
            m = 4'(i + 5);
            l = 4'(15 - i);
            transfer({h, m, l}, $sformatf("sweep%0d", i));
            chk($sformatf("sweep%0d_d2", i), enc[h], 0, 1, 0);
            repeat (HC) @(negedge clk);
            #1;
            chk($sformatf("sweep%0d_d1", i), enc[m], 0, 1, 0);
            repeat (HC) @(negedge clk);
            #1;
            chk($sformatf("sweep%0d_d0", i), enc[l], 1, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_digit_scroller.md
MULT_DIGIT_SCROLLER -- requirements
Module: mult_digit_scroller

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024, sets the number of clk cycles each display phase lasts; legal range 2..65535.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 prod_valid  input  1  upstream multiplier product is valid.
REQ-005 prod  input  12  unsigned 6x6 product from the multiplier stage.
REQ-006 prod_ready  output  1  block accepts a product this cycle.
REQ-007 segments  output  7  seven-segment drive, active-high, bit0=a ... bit6=g.
REQ-008 dp  output  1  decimal point, marks the least-significant digit.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 States SHALL be IDLE, DIG2, DIG1, DIG0 and GAP.
REQ-011 prod_ready SHALL be 1 in IDLE and GAP, and 0 in DIG2, DIG1 and DIG0.
REQ-012 Transfer SHALL occur on a rising edge with prod_valid=1 and prod_ready=1: prod is latched into a 12-bit hold register, the state goes to DIG2, and the phase counter is cleared.
REQ-013 prod_valid while prod_ready=0 SHALL be ignored with no side effect; upstream holds its data.
REQ-014 Each of DIG2, DIG1, DIG0 and GAP SHALL last exactly HOLD_CYCLES cycles, counted by one phase counter of width clog2(HOLD_CYCLES).
REQ-015 Phase sequence SHALL be DIG2 -> DIG1 -> DIG0 -> GAP.
REQ-016 When GAP expires without a transfer, the state SHALL return to DIG2 and the held value SHALL be redisplayed indefinitely.
REQ-017 A transfer during GAP, including on GAP's final cycle, SHALL take priority over expiry: the new value is loaded and the state goes to DIG2.
REQ-018 segments SHALL be decoded combinationally from registered state: DIG2 shows hold[11:8], DIG1 shows hold[7:4], DIG0 shows hold[3:0] as hex 0-F.
REQ-019 In GAP, segments SHALL be 0x00 (blank); in IDLE, segments SHALL be 0x40 (dash).
REQ-020 The hex encodings SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
REQ-021 dp SHALL be 1 only in DIG0.
REQ-022 Latency SHALL be one cycle: segments show digit 2 in the cycle after the transfer edge.
REQ-023 The phase counter SHALL wrap to 0 at each phase change and never exceed HOLD_CYCLES-1.

Reset
REQ-024 While rst=1, the block SHALL immediately force state=IDLE, hold=0 and counter=0.
REQ-025 Consequently, during reset the outputs SHALL be segments=0x40, dp=0, busy=0, prod_ready=1.
REQ-026 Reset asserted mid-display SHALL abandon the sequence, and no digit of the old value SHALL appear after release.
REQ-027 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-028 The state enumeration, the segment encoding constants and SEG_DASH/SEG_BLANK SHALL reside in the shared package mult_disp_pkg.
REQ-029 The hex-to-seven-segment decoder SHALL be a separate combinational sub-module, hex7seg (4-bit in, 7-bit out).
REQ-030 mult_digit_scroller SHALL contain only the FSM, the phase counter, the hold register and the output muxing.

Verification (HOLD_CYCLES=4)
REQ-031 Reset then idle: segments=0x40, dp=0, busy=0, prod_ready=1 on every cycle.
REQ-032 Single transfer of prod=0xA3F in IDLE: 4 cycles 0x77, then 4 cycles 0x4F, then 4 cycles 0x71 with dp=1, then 4 cycles 0x00, then repeating from 0x77.
REQ-033 prod_valid=1 with prod=0x123 during DIG1 of 0xA3F: no transfer, and the display of 0xA3F continues unchanged.
REQ-034 Transfer of 0x888 on the last GAP cycle of 0xA3F: the next cycle shows 0x7F, and the old value never reappears.
REQ-035 rst pulsed during DIG0 of 0x0F0: segments=0x40 immediately, and after release the block stays in IDLE with the dash displayed.
REQ-036 Sweep prod over all 16 nibble values in each digit position: every hex encoding matches REQ-020.
